// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and GF(2^8)/S-box helpers
package aes_pkg;

    localparam int NR = 10;

    // Byte 0 of a packed [0:15] array lands in bits [127:120], matching FIPS-197 order
    typedef logic [0:15][7:0] state_t;
    typedef logic [0:3][7:0]  word_t;
    typedef logic [1:0]       fsm_t;

    localparam fsm_t ST_IDLE    = 2'd0;
    localparam fsm_t ST_KEY_EXP = 2'd1;
    localparam fsm_t ST_DEC     = 2'd2;

    localparam logic [1:NR][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // With a constant multiplier this unrolls into a plain xtime/xor chain
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// rtl/aes_decrypt_core_if.sv - key/block request and result bundle of the decrypt core
interface aes_decrypt_core_if;
    logic [127:0] key_in;
    logic         load_key;
    logic         key_ready;
    logic [127:0] cipher_in;
    logic         start;
    logic         busy;
    logic [127:0] Dout;
    logic         done;

    modport master (
        output key_in, load_key, cipher_in, start,
        input  key_ready, busy, Dout, done
    );

    modport slave (
        input  key_in, load_key, cipher_in, start,
        output key_ready, busy, Dout, done
    );
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round; final_round skips InvMixColumns
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t state_in,
    input  state_t round_key,
    input  logic   final_round,
    output state_t state_out
);

    state_t shifted;
    state_t subbed;
    state_t keyed;
    state_t mixed;

    function automatic word_t inv_mix_column(input word_t a);
        word_t m;
        m[0] = gf_mul(a[0], 8'h0e) ^ gf_mul(a[1], 8'h0b) ^ gf_mul(a[2], 8'h0d) ^ gf_mul(a[3], 8'h09);
        m[1] = gf_mul(a[0], 8'h09) ^ gf_mul(a[1], 8'h0e) ^ gf_mul(a[2], 8'h0b) ^ gf_mul(a[3], 8'h0d);
        m[2] = gf_mul(a[0], 8'h0d) ^ gf_mul(a[1], 8'h09) ^ gf_mul(a[2], 8'h0e) ^ gf_mul(a[3], 8'h0b);
        m[3] = gf_mul(a[0], 8'h0b) ^ gf_mul(a[1], 8'h0d) ^ gf_mul(a[2], 8'h09) ^ gf_mul(a[3], 8'h0e);
        return m;
    endfunction

    // Row r rotates right by r columns; byte index is row + 4*column
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[r + 4 * c] = state_in[r + 4 * ((c - r + 4) % 4)];
            end
        end
    end

    always_comb begin
        subbed = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[i] = inv_sbox(shifted[i]);
        end
    end

    assign keyed = subbed ^ round_key;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[4 * c +: 4] = inv_mix_column(keyed[4 * c +: 4]);
        end
    end

    assign state_out = final_round ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES-128 decryptor: one-shot key schedule, one round per clock
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    aes_decrypt_core_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t       fsm;
    logic [3:0] round;
    state_t     blk;
    state_t     dout_q;
    logic       done_q;
    logic       key_ready_q;

    // Round-key buffer is deliberately not reset: key_ready gates every use of it
    state_t     rk [0:NR];
    logic       rk_we;
    logic [3:0] rk_idx;
    state_t     rk_wdata;
    state_t     inv_out;

    function automatic state_t expand_key(input state_t prev, input logic [7:0] rc);
        word_t  t;
        state_t nxt;
        t    = {sbox(prev[13]), sbox(prev[14]), sbox(prev[15]), sbox(prev[12])};
        t[0] = t[0] ^ rc;
        for (int i = 0; i < 4; i++) begin
            nxt[i] = prev[i] ^ t[i];
        end
        for (int i = 4; i < 16; i++) begin
            nxt[i] = prev[i] ^ nxt[i - 4];
        end
        return nxt;
    endfunction

    always_comb begin
        rk_we    = 1'b0;
        rk_idx   = 4'd0;
        rk_wdata = '0;
        case (fsm)
            ST_IDLE: begin
                if (bus.load_key) begin
                    rk_we    = 1'b1;
                    rk_idx   = 4'd0;
                    rk_wdata = bus.key_in;
                end
            end
            ST_KEY_EXP: begin
                rk_we    = 1'b1;
                rk_idx   = round;
                rk_wdata = expand_key(rk[round - 4'd1], RCON[round]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rk_we) rk[rk_idx] <= rk_wdata;
    end

    aes_inv_round u_inv_round (
        .state_in    (blk),
        .round_key   (rk[round]),
        .final_round (round == 4'd0),
        .state_out   (inv_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm         <= ST_IDLE;
            round       <= 4'd0;
            blk         <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (bus.load_key) begin
                        round       <= 4'd1;
                        key_ready_q <= 1'b0;
                        fsm         <= ST_KEY_EXP;
                    end else if (bus.start && key_ready_q) begin
                        blk   <= bus.cipher_in ^ rk[NR];
                        round <= LAST_ROUND - 4'd1;
                        fsm   <= ST_DEC;
                    end
                end
                ST_KEY_EXP: begin
                    if (round == LAST_ROUND) begin
                        key_ready_q <= 1'b1;
                        round       <= 4'd0;
                        fsm         <= ST_IDLE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                ST_DEC: begin
                    if (round == 4'd0) begin
                        dout_q <= inv_out;
                        done_q <= 1'b1;
                        fsm    <= ST_IDLE;
                    end else begin
                        blk   <= inv_out;
                        round <= round - 4'd1;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (fsm != ST_IDLE);
    assign bus.key_ready = key_ready_q;
    assign bus.Dout      = dout_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - self-checking bench for aes_decrypt_core
module tb_aes_decrypt_core;

    logic clock = 1'b0;
    logic reset = 1'b0;

    aes_decrypt_core_if bus();

    aes_decrypt_core dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vec_t         vecs [4];
    logic [127:0] sb [$];
    int           total    = 0;
    int           bad      = 0;
    int           done_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) check("unexpected_done", 128'd1, 128'd0);
            else check("dout", bus.Dout, sb.pop_front());
        end
    end

    task automatic load_key(input logic [127:0] key);
        int n;
        bus.key_in   = key;
        bus.load_key = 1'b1;
        tick();
        bus.load_key = 1'b0;
        check("key_ready_low_after_k0", {127'd0, bus.key_ready}, 128'd0);
        check("busy_in_key_exp", {127'd0, bus.busy}, 128'd1);
        n = 1;
        while (!bus.key_ready && n < 40) begin
            tick();
            n++;
        end
        check("key_latency", 128'(n), 128'd11);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt);
        int lat;
        bus.cipher_in = ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        sb.push_back(pt);
        wait_done(lat);
        check("dec_latency", 128'(lat), 128'd10);
        tick();
        check("done_one_cycle", {127'd0, bus.done}, 128'd0);
    endtask

    initial begin
        int           lat;
        int           d0;
        logic         have_key;
        logic [127:0] cur_key;

        vecs[0] = '{KEY_C1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{KEY_B,  128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{KEY_B,  128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[3] = '{KEY_B,  128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};

        bus.key_in    = '0;
        bus.load_key  = 1'b0;
        bus.cipher_in = '0;
        bus.start     = 1'b0;
        repeat (3) tick();
        check("reset_dout", bus.Dout, 128'd0);
        check("reset_done", {127'd0, bus.done}, 128'd0);
        check("reset_busy", {127'd0, bus.busy}, 128'd0);
        check("reset_key_ready", {127'd0, bus.key_ready}, 128'd0);
        reset = 1'b1;
        tick();

        // start before any key schedule exists
        d0 = done_cnt;
        bus.cipher_in = vecs[0].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("nokey_busy", {127'd0, bus.busy}, 128'd0);
        repeat (15) tick();
        check("nokey_no_done", 128'(done_cnt), 128'(d0));

        // table: C.1, then re-key to App. B and its vectors
        have_key = 1'b0;
        cur_key  = '0;
        for (int i = 0; i < 4; i++) begin
            if (!have_key || vecs[i].key != cur_key) begin
                load_key(vecs[i].key);
                have_key = 1'b1;
                cur_key  = vecs[i].key;
                if (cur_key == KEY_B) check("rk10_app_b", dut.rk[10], RK10_B);
            end
            decrypt(vecs[i].ct, vecs[i].pt);
        end

        // back-to-back: second start in the done cycle
        bus.cipher_in = vecs[2].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        sb.push_back(vecs[2].pt);
        wait_done(lat);
        check("b2b_first_latency", 128'(lat), 128'd10);
        bus.cipher_in = vecs[3].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        sb.push_back(vecs[3].pt);
        wait_done(lat);
        check("b2b_done_spacing", 128'(lat + 1), 128'd11);
        tick();

        // start and load_key pulsed mid-decryption are dropped
        d0 = done_cnt;
        bus.cipher_in = vecs[1].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        sb.push_back(vecs[1].pt);
        repeat (3) tick();
        check("dout_held_mid_dec", bus.Dout, vecs[3].pt);
        bus.cipher_in = vecs[2].ct;
        bus.key_in    = KEY_C1;
        bus.start     = 1'b1;
        bus.load_key  = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.load_key = 1'b0;
        wait_done(lat);
        check("mid_dec_latency", 128'(lat + 4), 128'd10);
        repeat (15) tick();
        check("mid_dec_single_done", 128'(done_cnt), 128'(d0 + 1));
        check("mid_dec_key_ready", {127'd0, bus.key_ready}, 128'd1);
        check("mid_dec_dout_held", bus.Dout, vecs[1].pt);
        decrypt(vecs[2].ct, vecs[2].pt);

        // asynchronous reset at E5 aborts
        bus.cipher_in = vecs[3].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("abort_dout", bus.Dout, 128'd0);
        check("abort_done", {127'd0, bus.done}, 128'd0);
        check("abort_busy", {127'd0, bus.busy}, 128'd0);
        check("abort_key_ready", {127'd0, bus.key_ready}, 128'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        d0 = done_cnt;
        bus.cipher_in = vecs[3].ct;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (15) tick();
        check("post_reset_no_done", 128'(done_cnt), 128'(d0));
        check("post_reset_key_ready", {127'd0, bus.key_ready}, 128'd0);

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
Iterative AES-128 decryption engine: the inverse counterpart of the existing encryption datapath and controller. It expands a 128-bit key once into an 11-entry round-key buffer, then decrypts one 128-bit block per request using the FIPS-197 inverse cipher, one round per clock. It sits beside the encryption core behind the same block-level start/done style interface.

Parameters:
NR, 10, number of AES rounds (fixed for AES-128; buffer depth is NR+1)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
key_in  input  128  cipher key, FIPS-197 byte order (byte 0 = bits [127:120])
load_key  input  1  one-cycle request to expand key_in
key_ready  output  1  high when the round-key buffer holds a complete schedule
cipher_in  input  128  ciphertext block, same byte order
start  input  1  one-cycle request to decrypt cipher_in
busy  output  1  high in KEY_EXP or DEC
Dout  output  128  plaintext result register
done  output  1  one-cycle pulse when Dout is updated

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; Dout=0, done=0, busy=0, key_ready=0; round counter=0; round-key buffer contents don't-care.
- States: IDLE, KEY_EXP, DEC.
- IDLE + load_key=1 (edge K0): rk[0]<=key_in, counter<=1, key_ready<=0, go to KEY_EXP. load_key has priority over start when both are high.
- KEY_EXP, edges K1..K10: rk[i]<=expand(rk[i-1], Rcon[i]) with i=counter, using the standard RotWord/SubWord/Rcon schedule. At K10: key_ready<=1, go to IDLE. Key expansion takes 11 cycles from load_key to key_ready.
- IDLE + start=1 + key_ready=1 (edge E0): state<=cipher_in ^ rk[10], counter<=9, go to DEC. start while key_ready=0 is ignored; no error flag.
- DEC, edges E1..E9: state<=InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[counter]), counter decrements.
- DEC, edge E10: Dout<=InvSubBytes(InvShiftRows(state)) ^ rk[0], done<=1 for exactly one cycle, go to IDLE.
- Latency: Dout and done are valid 10 cycles after the start-accept edge. The next start is accepted in the cycle done is high, giving back-to-back throughput of one block per 11 cycles.
- Dout holds its value until the next completed decryption. done is 0 in every other cycle.
- load_key or start while busy=1 is ignored and not queued.
- load_key in IDLE with key_ready=1 starts a re-expansion: key_ready drops at K0, and the old schedule is no longer usable.
- Reset mid-operation aborts immediately. key_ready=0 afterwards, so a fresh load_key is required.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. GF(2^8) reduction polynomial is 0x11b.
- InvMixColumns uses coefficients {0e,0b,0d,09}, computed with xtime chains (no multipliers).

Decomposition:
- Package aes_pkg holds:
  - forward S-box function (used by key expansion)
  - inverse S-box function
  - xtime and gf_mul helper functions
  - Rcon constant array
  - state typedef (state_t, FSM enum)
  - NR constant
- One sub-module, aes_inv_round: purely combinational. Inputs are state, round key, and a final flag (the flag bypasses InvMixColumns). Output is the next state.
- Key expansion step, round-key buffer, counter and FSM stay in aes_decrypt_core.

Test Plan:
- FIPS-197 C.1: load_key with 000102030405060708090a0b0c0d0e0f; wait for key_ready; start with 69c4e0d86a7b0430d8cdb78070b4c55a -> Dout=00112233445566778899aabbccddeeff, done high exactly 10 cycles after the start edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready 11 cycles after load_key, and internal rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6. Ciphertext 3925841d02dc09fbdc118597196a0b32 -> Dout=3243f6a8885a308d313198a2e0370734.
- Back-to-back: second start asserted in the done cycle -> both plaintexts correct, second done 11 cycles after the first.
- start with key_ready=0, and start/load_key pulsed mid-DEC -> ignored: no done, Dout unchanged, in-flight result correct.
- Reset driven low at E5 of a decryption -> outputs immediately 0, key_ready=0. A subsequent start without load_key produces no done.
- Re-key: after C.1, load_key with the App. B key, then decrypt its ciphertext -> App. B plaintext. key_ready is low throughout the 11-cycle re-expansion.
